parallellogic_top: RTL and testbench
====================================

Name: parallellogic_top

Overview:
Top-level of the parallellogic TinyTapeout tile: an 8-channel, 8-bit PWM generator.
- Duty values are written over a byte-wide bus on uio_in, addressed and strobed from ui_in.
- Each channel drives one uo_out pin from a shared, prescaled free-running counter.
- Duty updates are double-buffered and take effect only at the PWM period boundary, so outputs never glitch.

Parameters:
CNT_W, 8, PWM counter and duty width (fixed by the 8-bit data bus).
N_CH, 8, number of PWM channels (fixed by the uo_out width).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  tile-selected flag; ignored by logic
ui_in  input  8  [2:0] channel address, [3] write strobe, [4] output enable, [6:5] prescale select, [7] output invert
uo_out  output  8  PWM outputs, bit i = channel i
uio_in  input  8  duty data byte for writes
uio_out  output  8  tied 8'h00
uio_oe  output  8  tied 8'h00 (all uio pins are inputs)

Behaviour:
- Reset: async assert when rst_n=0.
  - Clears uo_out, all shadow and active duty registers, the counter, the prescaler and the strobe history register.
  - uio_out and uio_oe are constant 0.
- Write:
  - Strobe history register samples ui_in[3] every clock.
  - A write fires on the cycle where ui_in[3]=1 and history=0 (rising edge). A held-high strobe writes once.
  - On a write, shadow[ui_in[2:0]] <= uio_in, captured that same clock.
  - Address and data are sampled only on the edge cycle.
- Prescaler: tick period in clocks selected by ui_in[6:5]:
  - 00: 1 (tick every clock)
  - 01: 4
  - 10: 16
  - 11: 64
  - Prescaler is a 6-bit free-running counter; tick = its low bits all zero for the selected divide.
  - Changing the selection mid-run takes effect immediately; no reset of the prescaler.
- Counter: 8-bit, increments by 1 on each tick and wraps 255->0.
- Period boundary: on the tick where counter==255, all active[i] <= shadow[i] simultaneously with the wrap to 0.
  - A write in the same cycle as the boundary: the shadow gets the new value, active gets the old shadow value. The new duty applies at the following boundary.
- Compare: raw[i] = (counter < active[i]).
  - Duty 0 gives constantly low; duty 255 gives high 255 of 256 counts. 100% is not reachable.
- Output: uo_out[i] registered <= ui_in[4] ? (raw[i] XOR ui_in[7]) : 0.
  - One clock latency from counter/active state to pin.
  - With output enable low, all pins are 0 regardless of invert.
- ena has no effect. Logic runs whenever rst_n=1.

Decomposition:
- Package parallellogic_pkg: CNT_W, N_CH, prescale-select encodings (PS_DIV1/4/16/64), ui_in bit-index constants (ADDR_LSB, STROBE_BIT, OE_BIT, PS_LSB, INV_BIT).
- One sub-module, pwm_channel: holds the shadow/active duty registers, the boundary load and the compare. Instantiated N_CH times.
- Top holds the strobe edge detect, prescaler, counter and output register.

Test Plan:
- Reset: hold rst_n=0 with random ui_in/uio_in -> uo_out=0, uio_out=0, uio_oe=0. Release; with ui_in[4]=1 and no writes, uo_out stays 0 for 512 clocks.
- Basic PWM, prescale 00: write ch0=64 (strobe pulse) and wait for a boundary -> uo_out[0] high for exactly 64 of every 256 clocks. Other bits stay 0.
- Double-buffer: write ch3=200 mid-period -> current period keeps the old duty. 200-count high time starts at the first count after the next wrap. A write landing on the boundary cycle is delayed one extra period.
- Extremes, all channels: ch0=0, ch7=255 -> bit0 always 0; bit7 low exactly 1 clock per 256.
- Prescale 01 with ch1=128 -> high 512 clocks, low 512 clocks. Held strobe for 10 clocks with a changing uio_in -> only the first-cycle value is written.
- Invert/enable: ch2=32, ui_in[7]=1 -> bit2 high 224 of 256. ui_in[4]=0 -> all 0 one clock later. Async reset mid-period -> uo_out=0 immediately without a clock edge.

Source files
------------

// File: rtl/parallellogic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parallellogic_pkg                                               |
// | Purpose  : Shared widths, prescale-select encodings, ui_in bit positions   |
// |            and the prescaler tick decode for the parallellogic PWM tile.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package parallellogic_pkg;

  localparam int CNT_W = 8;  // PWM counter / duty width
  localparam int N_CH  = 8;  // number of PWM channels
  localparam int PS_W  = 6;  // prescaler width (largest divide is 64)

  // ui_in bit positions
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_W     = 3;
  localparam int STROBE_BIT = 3;
  localparam int OE_BIT     = 4;
  localparam int PS_LSB     = 5;
  localparam int INV_BIT    = 7;

  typedef logic [CNT_W-1:0] duty_t;

  typedef enum logic [1:0] {
    PS_DIV1  = 2'b00,
    PS_DIV4  = 2'b01,
    PS_DIV16 = 2'b10,
    PS_DIV64 = 2'b11
  } ps_sel_e;

  // A tick fires when the low bits of the free-running prescaler that cover
  // the selected divide are all zero. Because the prescaler never resets on a
  // selection change, a new divide takes effect on the very next clock.
  function automatic logic prescale_tick(input ps_sel_e sel, input logic [PS_W-1:0] ps);
    logic t;
    case (sel)
      PS_DIV1:  t = 1'b1;
      PS_DIV4:  t = (ps[1:0] == 2'b00);
      PS_DIV16: t = (ps[3:0] == 4'h0);
      default:  t = (ps == '0);
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parallellogic_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parallellogic_if                                                |
// | Purpose  : TinyTapeout tile pin bundle for the parallellogic PWM block.    |
// | Ports    : ena      tile-selected flag                                     |
// |            ui_in    [2:0] addr, [3] strobe, [4] OE, [6:5] prescale, [7] inv|
// |            uio_in   duty data byte                                         |
// |            uo_out   PWM outputs, bit i = channel i                         |
// |            uio_out  bidirectional output data (unused, zero)               |
// |            uio_oe   bidirectional output enables (all inputs, zero)        |
// |            master = pad/tile side driving the block, slave = the block     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface parallellogic_if;

  logic                            ena;
  logic [7:0]                      ui_in;
  logic [parallellogic_pkg::CNT_W-1:0] uio_in;
  logic [parallellogic_pkg::N_CH-1:0]  uo_out;
  logic [7:0]                      uio_out;
  logic [7:0]                      uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface
`default_nettype wire

// File: rtl/parallellogic_pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parallellogic_pwm_channel                                       |
// | Purpose  : One PWM channel: double-buffered duty (shadow + active) and the |
// |            counter compare.                                                |
// | Ports    : clk, rst_n  clock, async active-low reset                       |
// |            we          write this channel's shadow duty this clock         |
// |            wdata       duty byte to write                                  |
// |            boundary    period boundary: active takes the shadow value      |
// |            cnt         shared PWM counter                                  |
// |            raw         unregistered compare result (cnt < active)          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module parallellogic_pwm_channel
  import parallellogic_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  duty_t wdata,
  input  logic  boundary,
  input  duty_t cnt,
  output logic  raw
);

  duty_t shadow_q, shadow_d;
  duty_t active_q, active_d;

  // Active loads the registered shadow, so a write coinciding with a boundary
  // lands in the shadow but is only seen by the compare one period later.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (we) begin
      shadow_d = wdata;
    end
    if (boundary) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Strict less-than: duty 0 never high, duty 255 high 255 of 256 counts.
  assign raw = (cnt < active_q);

endmodule
`default_nettype wire

// File: rtl/parallellogic_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parallellogic_top                                               |
// | Purpose  : 8-channel, 8-bit PWM generator tile. Strobe edge detect,        |
// |            prescaler, shared counter, per-channel compare and the output   |
// |            register with enable/invert.                                    |
// | Ports    : clk    system clock                                             |
// |            rst_n  asynchronous active-low reset                            |
// |            bus    tile pins (slave side): ui_in/uio_in in, uo_out and the  |
// |                   constant-zero uio_out/uio_oe out; ena is ignored         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module parallellogic_top
  import parallellogic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  parallellogic_if.slave  bus
);

  logic [7:0]      ui;
  logic [ADDR_W-1:0] addr;
  ps_sel_e         ps_sel;
  logic            write_fire;
  logic            tick;
  logic            boundary;
  logic [N_CH-1:0] raw;

  logic            strobe_hist_q, strobe_hist_d;
  logic [PS_W-1:0] ps_q, ps_d;
  duty_t           cnt_q, cnt_d;
  logic [N_CH-1:0] uo_q, uo_d;

  // The tile-select flag carries no function for this block.
  logic unused_ena;
  assign unused_ena = bus.ena;

  assign ui     = bus.ui_in;
  assign addr   = ui[ADDR_LSB +: ADDR_W];
  assign ps_sel = ps_sel_e'(ui[PS_LSB +: 2]);

  // Rising edge of the strobe: a held-high strobe writes exactly once.
  assign write_fire = ui[STROBE_BIT] & ~strobe_hist_q;

  assign tick     = prescale_tick(ps_sel, ps_q);
  assign boundary = tick && (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    strobe_hist_d = ui[STROBE_BIT];
    ps_d          = ps_q + PS_W'(1);
    cnt_d         = cnt_q;
    if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    uo_d = '0;
    if (ui[OE_BIT]) begin
      uo_d = raw ^ {N_CH{ui[INV_BIT]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_hist_q <= 1'b0;
      ps_q          <= '0;
      cnt_q         <= '0;
      uo_q          <= '0;
    end else begin
      strobe_hist_q <= strobe_hist_d;
      ps_q          <= ps_d;
      cnt_q         <= cnt_d;
      uo_q          <= uo_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    parallellogic_pwm_channel u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (write_fire && (addr == ADDR_W'(i))),
      .wdata    (bus.uio_in),
      .boundary (boundary),
      .cnt      (cnt_q),
      .raw      (raw[i])
    );
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_parallellogic_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_parallellogic_top                                            |
// | Purpose  : Directed self-checking bench for parallellogic_top. Edge n is   |
// |            the n-th rising clock after reset release; with divide-by-1 the |
// |            counter before edge n is (n-1) mod 256 and the period boundary  |
// |            is edge 256*k. High-time checks count over whole periods.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_parallellogic_top;

  localparam logic [1:0] PS1 = 2'b00;
  localparam logic [1:0] PS4 = 2'b01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  parallellogic_if bus_if ();

  parallellogic_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int hi[8];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ui(input logic [2:0] addr, input logic stb,
                                    input logic oe, input logic [1:0] ps,
                                    input logic inv);
    return {inv, ps, oe, stb, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int t);
    while (n < t) step();
  endtask

  // Count, per output bit, how many of the next `cycles` samples are high.
  task automatic count_win(input int cycles);
    for (int b = 0; b < 8; b++) hi[b] = 0;
    repeat (cycles) begin
      step();
      for (int b = 0; b < 8; b++) hi[b] += bus_if.uo_out[b] ? 1 : 0;
    end
  endtask

  function automatic int hsum(input int lo, input int top);
    int s = 0;
    for (int b = lo; b <= top; b++) s += hi[b];
    return s;
  endfunction

  initial begin
    bus_if.ena    = 1'b1;
    bus_if.ui_in  = 8'($urandom);
    bus_if.uio_in = 8'($urandom);

    // ---------------- reset with random inputs ----------------
    repeat (3) begin
      @(negedge clk);
      bus_if.ui_in  = 8'($urandom);
      bus_if.uio_in = 8'($urandom);
    end
    #1;
    check("reset_uo_out",  int'(bus_if.uo_out),  0);
    check("reset_uio_out", int'(bus_if.uio_out), 0);
    check("reset_uio_oe",  int'(bus_if.uio_oe),  0);

    @(negedge clk);
    bus_if.ui_in  = ui(3'd0, 1'b0, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'h00;
    rst_n = 1'b1;
    n = 0;

    count_win(512);
    check("idle_all_zero", hsum(0, 7), 0);

    // ---------------- basic PWM ch0 = 64 ----------------
    bus_if.ui_in  = ui(3'd0, 1'b1, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'd64;
    step();                                   // edge 513: write
    bus_if.ui_in  = ui(3'd0, 1'b0, 1'b1, PS1, 1'b0);
    step_to(768);                             // boundary edge
    check("ch0_before_load", int'(bus_if.uo_out[0]), 0);
    step();                                   // edge 769: count 0 < 64
    check("ch0_first_high", int'(bus_if.uo_out[0]), 1);
    count_win(256);                           // edges 770..1025
    check("ch0_high_64", hi[0], 64);
    check("others_zero", hsum(1, 7), 0);

    // ---------------- double buffer ch3 = 200 ----------------
    bus_if.ui_in  = ui(3'd3, 1'b1, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'd200;
    step();                                   // edge 1026: mid-period write
    bus_if.ui_in  = ui(3'd3, 1'b0, 1'b1, PS1, 1'b0);
    count_win(254);                           // edges 1027..1280
    check("ch3_old_duty_kept", hi[3], 0);
    step();                                   // edge 1281: first count after wrap
    check("ch3_first_high", int'(bus_if.uo_out[3]), 1);
    count_win(256);                           // edges 1282..1537
    check("ch3_high_200", hi[3], 200);
    check("ch0_still_64", hi[0], 64);

    // write landing exactly on the boundary edge 1792
    step_to(1791);
    bus_if.ui_in  = ui(3'd3, 1'b1, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'd16;
    step();
    bus_if.ui_in  = ui(3'd3, 1'b0, 1'b1, PS1, 1'b0);
    count_win(256);                           // edges 1793..2048
    check("ch3_boundary_write_delayed", hi[3], 200);
    count_win(256);                           // edges 2049..2304
    check("ch3_high_16", hi[3], 16);

    // ---------------- extremes ch0 = 0, ch7 = 255 ----------------
    bus_if.ui_in  = ui(3'd0, 1'b1, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'd0;
    step();
    bus_if.ui_in  = ui(3'd0, 1'b0, 1'b1, PS1, 1'b0);
    step();
    bus_if.ui_in  = ui(3'd7, 1'b1, 1'b1, PS1, 1'b0);
    bus_if.uio_in = 8'd255;
    step();
    bus_if.ui_in  = ui(3'd7, 1'b0, 1'b1, PS1, 1'b0);
    step_to(2560);
    count_win(256);                           // edges 2561..2816
    check("ch0_duty0_low", hi[0], 0);
    check("ch7_duty255", hi[7], 255);
    check("ch3_unchanged", hi[3], 16);

    // ---------------- prescale /4, ch1 = 128, held strobe ----------------
    bus_if.ena    = 1'b0;
    bus_if.ui_in  = ui(3'd1, 1'b1, 1'b1, PS4, 1'b0);
    bus_if.uio_in = 8'd128;
    step();
    for (int k = 1; k <= 9; k++) begin
      bus_if.uio_in = 8'(16 + k);
      step();
    end
    bus_if.ui_in = ui(3'd1, 1'b0, 1'b1, PS4, 1'b0);
    repeat (1100) step();
    count_win(1024);
    check("ch1_div4_high_512", hi[1], 512);
    check("ch7_div4_high_1020", hi[7], 1020);
    check("ch0_div4_low", hi[0], 0);

    // ---------------- invert / enable / async reset ----------------
    bus_if.ui_in  = ui(3'd2, 1'b1, 1'b1, PS1, 1'b1);
    bus_if.uio_in = 8'd32;
    step();
    bus_if.ui_in  = ui(3'd2, 1'b0, 1'b1, PS1, 1'b1);
    repeat (600) step();
    count_win(256);
    check("ch2_inverted_224", hi[2], 224);
    check("ch0_inverted_256", hi[0], 256);
    check("ch7_inverted_1", hi[7], 1);
    check("inv_bit0_high", int'(bus_if.uo_out[0]), 1);

    bus_if.ui_in = ui(3'd2, 1'b0, 1'b0, PS1, 1'b1);
    step();
    check("oe_low_all_zero", int'(bus_if.uo_out), 0);

    bus_if.ui_in = ui(3'd2, 1'b0, 1'b1, PS1, 1'b1);
    step();
    step();
    check("oe_restored_bit0", int'(bus_if.uo_out[0]), 1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo_out", int'(bus_if.uo_out), 0);

    @(negedge clk);
    bus_if.ui_in = ui(3'd0, 1'b0, 1'b1, PS1, 1'b0);
    rst_n = 1'b1;
    n = 0;
    count_win(512);
    check("duties_cleared_by_reset", hsum(0, 7), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
